main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Behavioural/synthesizable main-memory end of the cache refill interface.
- Accepts a line-fill request (line address from the cache) and, after a fixed access latency, returns the line as a burst of one word per cycle on mem_data, qualified by we.
- Provides a single-word write port for preload and write-back.
- Used as the backing store for the cache in simulation and on board.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 32, byte address width.
- DEPTH_LOG2, 10, log2 of the number of storage words; word index = addr[DEPTH_LOG2+1:2].
- LINE_WORDS, 4, words per line (power of 2, range 2..16).
- LATENCY, 4, access cycles before the first beat (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- req  in  1  line-fill request; sampled only while idle.
- mem_addr  in  ADDR_W  byte address of the requested line; low log2(LINE_WORDS)+2 bits ignored (line-aligned).
- wr_en  in  1  single-word write strobe.
- wr_addr  in  ADDR_W  byte address of the write; bits [1:0] ignored.
- wr_data  in  DATA_W  write data.
- mem_data  out  DATA_W  burst data to the cache (registered).
- we  out  1  beat valid; cache captures mem_data when we=1.
- last  out  1  final beat of the burst; asserted together with we.
- busy  out  1  high while a request is in progress (state != IDLE).

Behaviour:
- Clock/reset (already decided): one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset values: mem_data=0, we=0, last=0, busy=0, state=IDLE, counters=0.
- Storage array is not reset; contents survive rst.
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - On an edge with req=1, latch base = line-aligned word index of mem_addr.
  - Load lat_cnt = LATENCY-1, go to WAIT. busy=1 from this edge.
- WAIT:
  - Each edge decrements lat_cnt.
  - On the edge where lat_cnt==0: go to BURST, register beat 0 (mem_data=mem[base], we=1, beat_cnt=1).
- BURST:
  - Each edge registers mem_data=mem[base+beat_cnt], we=1, then increments beat_cnt.
  - The beat registered with beat_cnt==LINE_WORDS-1 also sets last=1.
  - On the edge after the last beat: we=0, last=0, mem_data holds its last value, state=IDLE, busy=0.
- Timing: req accepted at edge T0 → we=1 after edges T0+LATENCY .. T0+LATENCY+LINE_WORDS-1 → IDLE after edge T0+LATENCY+LINE_WORDS. The earliest next request is accepted at that same edge.
- Beat order: sequential from the aligned base. Word index wraps modulo 2^DEPTH_LOG2; the line stays inside the array because base is line-aligned.
- Address bits above DEPTH_LOG2+1 are ignored (aliasing).
- req while busy: ignored, not queued.
- mem_addr is sampled only at acceptance; changes during the burst have no effect.
- Write port:
  - wr_en writes mem[wr_addr index]=wr_data at the edge, in any state.
  - If a write targets the word being registered as a beat on the same edge, the beat carries wr_data (write-first bypass).
  - A write to an already-sent or not-yet-sent word of the line behaves naturally: not-yet-sent words return the new data.
- Reset mid-operation: outputs and FSM clear immediately (asynchronously). The burst is abandoned with no further we. A write on the reset edge is dropped.
- Exactly LINE_WORDS we pulses per accepted request; we is never high in IDLE or WAIT.

Test Plan:
- Preload via wr_en: 0x40→0x1111_0000, 0x44→0x2222_0001, 0x48→0x3333_0002, 0x4C→0x4444_0003; reset; req=1, mem_addr=0x0000_0048 at edge T0 → busy=1 after T0. we=1 after T0+4..T0+7 with mem_data 0x11110000, 0x22220001, 0x33330002, 0x44440003. last=1 only on the 4th beat. busy=0 after T0+8.
- Hold req=1 continuously across two bursts to 0x40 then 0x80 (change mem_addr at T0+8) → second request accepted at T0+8, its first beat after T0+12. req pulses at T0+2 and T0+6 are ignored; exactly 8 we pulses in total.
- Burst from 0x40; at the edge registering beat 2 assert wr_en, wr_addr=0x48, wr_data=0xDEAD_BEEF → beat 2 = 0xDEADBEEF. A later re-read of 0x40 returns 0xDEADBEEF as beat 2.
- Assert rst asynchronously mid-burst (after the 2nd beat) → we, last, busy and mem_data go to 0 immediately. No further beats. Preloaded data is still returned correctly by the next request.
- Wrap/alias with DEPTH_LOG2=10: write 0x0FFC=0xCAFE_0001; req mem_addr=0x0000_1FF0 → line indices 1020..1023, 4th beat 0xCAFE0001. req 0x0000_0FF4 returns the same line.
- Parameter sweep LATENCY=1, LINE_WORDS=8 → first we after edge T0+1, 8 consecutive beats, last on the 8th, busy low after T0+9.

Source files
------------

// File: rtl/main_mem_responder.sv
// Main-memory end of the cache refill path: accepts a line-fill request and,
// after a fixed latency, streams the line one word per cycle; also has a single-word write port.
module main_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] mem_data,
  output logic              we,
  output logic              last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LW_LOG2 = $clog2(LINE_WORDS);
  localparam int IDX_W   = DEPTH_LOG2;

  localparam logic [3:0]       LAT_INIT  = 4'(LATENCY - 1);
  localparam logic [LW_LOG2:0] LAST_BEAT = (LW_LOG2 + 1)'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // Handshake: the cache captures mem_data on every cycle we=1; there is no
  // back-pressure, and last marks the final beat of the line together with we.
  // req is only looked at in IDLE, or on the edge that closes a burst.

  state_t             state_q;
  logic [IDX_W-1:0]   base_q;
  logic [3:0]         lat_cnt_q;
  logic [LW_LOG2:0]   beat_cnt_q;
  logic [DATA_W-1:0]  mem_data_q;
  logic               we_q;
  logic               last_q;
  logic               busy_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [LW_LOG2-1:0] beat_off;
  logic [DATA_W-1:0]  rd_word;
  logic               unused_addr_bits;

  assign req_idx  = {mem_addr[DEPTH_LOG2+1:LW_LOG2+2], {LW_LOG2{1'b0}}};
  assign wr_idx   = wr_addr[DEPTH_LOG2+1:2];
  assign beat_off = (state_q == S_BURST) ? beat_cnt_q[LW_LOG2-1:0] : '0;
  // base is line-aligned, so OR-ing the offset never leaves the line.
  assign rd_idx   = base_q | {{(IDX_W-LW_LOG2){1'b0}}, beat_off};
  assign rd_word  = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  assign unused_addr_bits = ^{mem_addr[LW_LOG2+1:0], mem_addr[ADDR_W-1:DEPTH_LOG2+2],
                              wr_addr[1:0], wr_addr[ADDR_W-1:DEPTH_LOG2+2]};

  // Storage keeps its contents across reset; only a write landing on a reset edge is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            base_q    <= req_idx;
            lat_cnt_q <= LAT_INIT;
            state_q   <= S_WAIT;
            busy_q    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            state_q    <= S_BURST;
            mem_data_q <= rd_word;
            we_q       <= 1'b1;
            last_q     <= 1'b0;
            beat_cnt_q <= (LW_LOG2 + 1)'(1);
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        S_BURST: begin
          if (last_q) begin
            we_q       <= 1'b0;
            last_q     <= 1'b0;
            beat_cnt_q <= '0;
            // A request on the closing edge starts the next access back to back.
            if (req) begin
              base_q    <= req_idx;
              lat_cnt_q <= LAT_INIT;
              state_q   <= S_WAIT;
              busy_q    <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            mem_data_q <= rd_word;
            we_q       <= 1'b1;
            last_q     <= (beat_cnt_q == LAST_BEAT);
            beat_cnt_q <= beat_cnt_q + (LW_LOG2 + 1)'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data  = mem_data_q;
  assign we        = we_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: a default instance and a LATENCY=1/LINE_WORDS=8 instance
// share one stimulus stream and are checked every cycle against an edge-count model.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] data0, data1;
  logic        we0, we1, last0, last1, busy0, busy1;
  logic [1:0]  dbg0, dbg1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  main_mem_responder u_dut0 (
    .clk(clk), .rst(rst), .req(req), .mem_addr(mem_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_data(data0), .we(we0), .last(last0), .busy(busy0), .dbg_state(dbg0)
  );

  main_mem_responder #(.LATENCY(1), .LINE_WORDS(8)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .mem_addr(mem_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_data(data1), .we(we1), .last(last1), .busy(busy1), .dbg_state(dbg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a request accepted at edge A produces beat k at edge A+LAT+k.
  logic [31:0] smem [1024];
  int          lat_p [2] = '{4, 1};
  int          lw_p  [2] = '{4, 8};
  int          cyc = 0;
  int          acc [2];
  int          base [2];
  bit          act [2] = '{0, 0};
  logic [31:0] e_data [2] = '{32'h0, 32'h0};
  logic        e_we [2] = '{1'b0, 1'b0};
  logic        e_last [2] = '{1'b0, 1'b0};
  logic        e_busy [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; e_data[i] = '0; e_we[i] = 0; e_last[i] = 0; e_busy[i] = 0;
      end
    end else begin
      if (wr_en) smem[int'((wr_addr >> 2) & 32'h3FF)] = wr_data;
      for (int i = 0; i < 2; i++) begin
        e_we[i] = 0;
        e_last[i] = 0;
        if (act[i]) begin
          int k;
          k = cyc - acc[i] - lat_p[i];
          if (k >= 0 && k < lw_p[i]) begin
            e_we[i] = 1;
            e_data[i] = smem[(base[i] + k) % 1024];
            e_last[i] = (k == lw_p[i] - 1);
          end else if (k >= lw_p[i]) begin
            act[i] = 0;
          end
        end
        if (!act[i] && req) begin
          act[i] = 1;
          acc[i] = cyc;
          base[i] = int'((mem_addr >> 2) & 32'h3FF) & ~(lw_p[i] - 1);
        end
        e_busy[i] = act[i];
      end
    end
    #1;
    chk("data0", data0, e_data[0]);
    chk1("we0", we0, e_we[0]);
    chk1("last0", last0, e_last[0]);
    chk1("busy0", busy0, e_busy[0]);
    chk1("state0_active", dbg0 != 2'd0, e_busy[0]);
    chk("data1", data1, e_data[1]);
    chk1("we1", we1, e_we[1]);
    chk1("last1", last1, e_last[1]);
    chk1("busy1", busy1, e_busy[1]);
    chk1("state1_active", dbg1 != 2'd0, e_busy[1]);
  end

  logic [31:0] exp_q[$];

  initial begin
    int cnt;
    logic [31:0] lit [4];
    lit[0] = 32'h1111_0000; lit[1] = 32'h2222_0001;
    lit[2] = 32'h3333_0002; lit[3] = 32'h4444_0003;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_data", data0, 32'h0);
    chk1("rst_we", we0, 1'b0);
    chk1("rst_last", last0, 1'b0);
    chk1("rst_busy", busy0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Fill the whole array so every beat has a known value
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1'b1; wr_addr = 32'(i) << 2; wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0;

    // Basic line fill from a mid-line address
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 32'h40 + 32'(i * 4); wr_data = lit[i];
      tick();
    end
    wr_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(lit[i]);
    req = 1'b1; mem_addr = 32'h48;
    tick();
    chk1("t1_busy_t0", busy0, 1'b1);
    chk1("t1_busy1_t0", busy1, 1'b1);
    req = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk1("t1_we", we0, (e >= 4 && e <= 7));
      chk1("t1_last", last0, (e == 7));
      chk1("t1_busy", busy0, (e < 8));
      chk1("t1_we_l1", we1, (e >= 1 && e <= 8));
      chk1("t1_last_l1", last1, (e == 8));
      chk1("t1_busy_l1", busy1, (e < 9));
      if (we0) begin
        if (exp_q.size() == 0) chk1("t1_extra_beat", 1'b1, 1'b0);
        else chk("t1_beat", data0, exp_q.pop_front());
      end
    end
    chk("t1_beats_left", 32'(exp_q.size()), 32'h0);

    // Back-to-back bursts with req held high
    cnt = 0;
    req = 1'b1; mem_addr = 32'h40;
    for (int e = 0; e <= 20; e++) begin
      if (e == 8) mem_addr = 32'h80;
      if (e == 9) req = 1'b0;
      tick();
      if (we0) cnt++;
      if (e == 8) chk1("t2_busy_t8", busy0, 1'b1);
      if (e == 11) chk1("t2_we_t11", we0, 1'b0);
      if (e == 12) chk1("t2_we_t12", we0, 1'b1);
    end
    chk("t2_we_count", 32'(cnt), 32'd8);

    // Write-first bypass onto the beat being registered
    req = 1'b1; mem_addr = 32'h40;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      wr_en = (e == 6); wr_addr = 32'h48; wr_data = 32'hDEAD_BEEF;
      tick();
      if (e == 6) chk("t3_bypass", data0, 32'hDEAD_BEEF);
    end
    wr_en = 1'b0;
    req = 1'b1; mem_addr = 32'h40;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) chk("t3_reread", data0, 32'hDEAD_BEEF);
    end

    // Asynchronous reset after the second beat
    req = 1'b1; mem_addr = 32'h40;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    #2 rst = 1'b1;
    #1;
    chk("t4_data", data0, 32'h0);
    chk1("t4_we", we0, 1'b0);
    chk1("t4_last", last0, 1'b0);
    chk1("t4_busy", busy0, 1'b0);
    chk1("t4_busy1", busy1, 1'b0);
    tick();
    rst = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    req = 1'b1; mem_addr = 32'h40;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4) chk("t4_after_rst", data0, 32'h1111_0000);
    end

    // Index wrap and high-bit aliasing
    wr_en = 1'b1; wr_addr = 32'h0FFC; wr_data = 32'hCAFE_0001;
    tick();
    wr_en = 1'b0;
    req = 1'b1; mem_addr = 32'h1FF0;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 7) begin
        chk("t5_alias_a", data0, 32'hCAFE_0001);
        chk1("t5_last_a", last0, 1'b1);
      end
    end
    req = 1'b1; mem_addr = 32'h0FF4;
    tick();
    req = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 7) chk("t5_alias_b", data0, 32'hCAFE_0001);
    end

    // Random traffic, concentrated on a small window so writes hit live lines
    for (int n = 0; n < 4000; n++) begin
      req      = ($urandom_range(0, 3) == 0);
      mem_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      wr_data  = $urandom;
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req = 1'b0; wr_en = 1'b0;
    for (int e = 0; e < 20; e++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
